// File: rtl/mem_wb_stage_if.sv
// Bundle between the MEM/WB stage and its environment: retiring instruction,
// data-memory return and register-file write port.
interface mem_wb_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              valid;
    logic              ready;
    logic              wreg;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] alu_result;
    logic              is_load;
    logic [2:0]        load_type;
    logic              flush;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_rvalid;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_req;

    modport master (
        output valid, wreg, waddr, alu_result, is_load, load_type, flush, dm_rdata, dm_rvalid,
        input  ready, rf_we, rf_waddr, rf_wdata, stall_req
    );

    modport slave (
        input  valid, wreg, waddr, alu_result, is_load, load_type, flush, dm_rdata, dm_rvalid,
        output ready, rf_we, rf_waddr, rf_wdata, stall_req
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Final pipeline stage: retires ALU results directly and waits for load data,
// extracting and extending the addressed byte/halfword before the register write.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    mem_wb_stage_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StWaitLoad} state_e;

    state_e            state_q, state_d;
    logic              ld_wreg_q, ld_wreg_d;
    logic [ADDR_W-1:0] ld_waddr_q, ld_waddr_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic [2:0]        ld_type_q, ld_type_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        byte_sel = bus.dm_rdata[{ld_off_q, 3'b000} +: 8];
        half_sel = ld_off_q[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
        case (ld_type_q)
            3'b000:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
            3'b001:  load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_data = bus.dm_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ld_wreg_d  = ld_wreg_q;
        ld_waddr_d = ld_waddr_q;
        ld_off_d   = ld_off_q;
        ld_type_d  = ld_type_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        case (state_q)
            StIdle: begin
                // Flush wins over is_load; rvalid is never looked at here.
                if (bus.valid && !bus.flush) begin
                    if (bus.is_load) begin
                        ld_wreg_d  = bus.wreg;
                        ld_waddr_d = bus.waddr;
                        ld_off_d   = bus.alu_result[1:0];
                        ld_type_d  = bus.load_type;
                        state_d    = StWaitLoad;
                    end else begin
                        we_d    = bus.wreg && (bus.waddr != '0);
                        waddr_d = bus.waddr;
                        wdata_d = bus.alu_result;
                    end
                end
            end
            StWaitLoad: begin
                if (bus.dm_rvalid) begin
                    we_d    = ld_wreg_q && (ld_waddr_q != '0);
                    waddr_d = ld_waddr_q;
                    wdata_d = load_data;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ld_wreg_q  <= 1'b0;
            ld_waddr_q <= '0;
            ld_off_q   <= '0;
            ld_type_q  <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ld_wreg_q  <= ld_wreg_d;
            ld_waddr_q <= ld_waddr_d;
            ld_off_q   <= ld_off_d;
            ld_type_q  <= ld_type_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.ready     = (state_q == StIdle);
    assign bus.stall_req = (state_q != StIdle);
    assign bus.rf_we     = we_q;
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Final pipeline stage between the data-memory interface and the register file.
- Accepts retiring instructions from the EX/MEM register and waits for load data when required.
- Performs load byte/halfword extraction with sign or zero extension.
- Drives the register file write port (we, waddr, wdata) as registered, one-cycle pulses.
- Raises a stall request upstream while a load is outstanding.

Parameters:
DATA_W, 32, datapath / register width
ADDR_W, 5, register address width (log2 of register count)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  upstream presents a retiring instruction this cycle
ready_o  output  1  stage can accept; transfer occurs when valid_i && ready_o at posedge
wreg_i  input  1  instruction writes a register
waddr_i  input  ADDR_W  destination register
alu_result_i  input  DATA_W  ALU result, or effective address for loads
is_load_i  input  1  instruction is a load
load_type_i  input  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
flush_i  input  1  kill the instruction presented this cycle
dm_rdata_i  input  DATA_W  aligned 32-bit word returned by data memory
dm_rvalid_i  input  1  dm_rdata_i valid (single-cycle pulse)
we_o  output  1  register file write enable
waddr_o  output  ADDR_W  register file write address
wdata_o  output  DATA_W  register file write data
stall_req_o  output  1  upstream must hold; equals !ready_o

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - we_o=0, waddr_o=0, wdata_o=0.
  - Captured instruction fields are cleared.
  - ready_o=1 and stall_req_o=0 once in IDLE.
- The FSM has two states, IDLE and WAIT_LOAD. ready_o=1 only in IDLE and is a combinational decode of state only.
- IDLE, accept without flush, non-load:
  - Next cycle: we_o = wreg_i && (waddr_i != 0), waddr_o = waddr_i, wdata_o = alu_result_i.
  - Latency is one cycle. Back-to-back accepts are allowed, one per cycle.
- IDLE, accept without flush, load:
  - Latch waddr_i, wreg_i, alu_result_i[1:0] and load_type_i, then go to WAIT_LOAD.
  - we_o=0 next cycle.
- IDLE, flush_i=1 with valid_i:
  - The instruction is dropped and the state stays IDLE.
  - we_o=0 next cycle.
  - flush_i has priority over is_load_i.
- IDLE, no accept: we_o=0 next cycle. waddr_o and wdata_o hold their last values.
- WAIT_LOAD, general:
  - ready_o=0 and stall_req_o=1.
  - valid_i is ignored and flush_i is ignored, because the load has already committed.
  - we_o=0 while waiting.
- WAIT_LOAD, dm_rvalid_i=1:
  - Extract the result from dm_rdata_i using the latched offset off[1:0]:
    - LB/LBU: byte off, sign- or zero-extended respectively.
    - LH/LHU: halfword off[1] (bits 15:0 if off[1]=0, bits 31:16 if off[1]=1); off[0] is ignored.
    - LW: the full word; the offset is ignored.
    - Undefined funct3: treated as LW.
  - Next cycle: we_o = latched wreg && (latched waddr != 0), waddr_o = latched waddr, wdata_o = extracted value.
  - The state returns to IDLE and ready_o rises in that same next cycle.
- dm_rvalid_i is sampled only in WAIT_LOAD. A pulse in IDLE, including one on the same cycle a load is accepted, is ignored.
- The load-to-write latency is therefore 1 cycle after dm_rvalid_i. Total latency is at least 2 cycles from accept.
- The register file forwards wdata during the we_o cycle, so no internal bypass is required.
- Reset asserted in WAIT_LOAD aborts the load with no write. A dm_rvalid_i arriving after reset releases is ignored.
- we_o is never high for more than one cycle per accepted instruction.
- waddr_o=0 is never written with we_o=1.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle -> we_o=0, waddr_o=0, wdata_o=0, ready_o=1 immediately, with no clock edge needed.
2. ALU writeback: valid_i=1, wreg_i=1, waddr_i=5, alu_result_i=0x1234_5678 -> next cycle we_o=1, waddr_o=5, wdata_o=0x1234_5678; following cycle we_o=0.
3. x0 suppression: valid_i=1, wreg_i=1, waddr_i=0, alu_result_i=0xFFFF_FFFF -> we_o stays 0 for all cycles.
4. Load extraction, dm_rdata_i=0x80F0_7F81, dm_rvalid_i 3 cycles after accept:
   - LB off=0 -> 0xFFFF_FF81
   - LBU off=1 -> 0x0000_007F
   - LH off=2 -> 0xFFFF_80F0
   - LHU off=2 -> 0x0000_80F0
   - LW off=0 -> 0x80F0_7F81
   - In each case stall_req_o=1 for exactly 3 cycles and we_o pulses once.
5. Flush and spurious rvalid:
   - valid_i=1, is_load_i=1, flush_i=1 -> state stays IDLE, stall_req_o=0, no write.
   - A dm_rvalid_i=1 pulse in IDLE -> no write.
6. Reset mid-load: accept LW to x7, assert rst_n=0 in WAIT_LOAD, release, then pulse dm_rvalid_i -> no write to x7, ready_o=1.
